// File: rtl/seg16_message_scroller_if.sv
// Character write channel of seg16_message_scroller: valid/ready handshake
// carrying one character per transfer plus an end-of-message marker.
interface seg16_message_scroller_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/seg16_message_scroller.sv
// Stores a message, then shows it one character at a time (dwell, blank gap) on a
// common-anode 16-segment display, looping forever. `SEG16_PWM_DIM_EN adds PWM dimming.
module seg16_message_scroller #(
  parameter int MSG_DEPTH    = 8,
  parameter int DWELL_CYCLES = 16777216,
  parameter int BLANK_CYCLES = 1048576
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  seg16_message_scroller_if.slave      wr,
  input  logic                         abort,
`ifdef SEG16_PWM_DIM_EN
  input  logic [3:0]                   brightness,
`endif
  output logic                         busy,
  output logic [$clog2(MSG_DEPTH)-1:0] char_index,
  output logic [15:0]                  seg_n,
  output logic                         dp_n
);
  localparam int IDX_W   = $clog2(MSG_DEPTH);
  localparam int FILL_W  = IDX_W + 1;
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0]  DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [FILL_W-1:0] FULL_MINUS1 = FILL_W'(MSG_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, GAP} state_e;

  // Lit-segment font, bits 15..0 = a,b,c,d,e,f,g,h,k,m,n,u,p,t,s,r; lowercase folds to uppercase.
  function automatic logic [15:0] seg_lit(input logic [6:0] code);
    logic [6:0] up;
    up = (code >= 7'h61 && code <= 7'h7A) ? code - 7'h20 : code;
    case (up)
      7'h20: seg_lit = 16'h0000;  7'h2D: seg_lit = 16'h0018;
      7'h30: seg_lit = 16'hFF00;  7'h31: seg_lit = 16'h3000;
      7'h32: seg_lit = 16'hEE18;  7'h33: seg_lit = 16'hFC18;
      7'h34: seg_lit = 16'h3118;  7'h35: seg_lit = 16'hDD18;
      7'h36: seg_lit = 16'hDF18;  7'h37: seg_lit = 16'hF000;
      7'h38: seg_lit = 16'hFF18;  7'h39: seg_lit = 16'hFD18;
      7'h41: seg_lit = 16'hF318;  7'h42: seg_lit = 16'hFC52;
      7'h43: seg_lit = 16'hCF00;  7'h44: seg_lit = 16'hFC42;
      7'h45: seg_lit = 16'hCF08;  7'h46: seg_lit = 16'hC308;
      7'h47: seg_lit = 16'hDF10;  7'h48: seg_lit = 16'h3318;
      7'h49: seg_lit = 16'hCC42;  7'h4A: seg_lit = 16'h3E00;
      7'h4B: seg_lit = 16'h032C;  7'h4C: seg_lit = 16'h0F00;
      7'h4D: seg_lit = 16'h33A0;  7'h4E: seg_lit = 16'h3384;
      7'h4F: seg_lit = 16'hFF00;  7'h50: seg_lit = 16'hE318;
      7'h51: seg_lit = 16'hFF04;  7'h52: seg_lit = 16'hE31C;
      7'h53: seg_lit = 16'hDD18;  7'h54: seg_lit = 16'hC042;
      7'h55: seg_lit = 16'h3F00;  7'h56: seg_lit = 16'h0321;
      7'h57: seg_lit = 16'h3305;  7'h58: seg_lit = 16'h00A5;
      7'h59: seg_lit = 16'h00A2;  7'h5A: seg_lit = 16'hCC21;
      default: seg_lit = 16'hFFFF;
    endcase
  endfunction

  state_e            state_q;
  logic [FILL_W-1:0] fill_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       seg_n_q, seg_n_d;
  logic              dp_n_q, dp_n_d;
  logic [7:0]        msg_mem [MSG_DEPTH];
  logic [7:0]        cur_char;
  logic              wr_fire;
  logic              drive_on;

  assign wr.wr_ready = ((state_q == IDLE) || (state_q == LOAD)) && (fill_q < FILL_W'(MSG_DEPTH));
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign busy        = (state_q == SHOW) || (state_q == GAP);
  assign char_index  = idx_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;

  // NOTE: the buffer is deliberately not reset; only characters written since the last
  // reset/abort are ever addressed, so reset logic here would buy nothing.
  always_ff @(posedge CLK) begin
    if (wr_fire && !abort) msg_mem[fill_q[IDX_W-1:0]] <= wr.wr_data;
  end

`ifdef SEG16_PWM_DIM_EN
  logic [3:0] pwm_q;
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) pwm_q <= '0;
    else          pwm_q <= pwm_q + 4'd1;
  end
  assign drive_on = (pwm_q < brightness);
`else
  assign drive_on = 1'b1;
`endif

  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    seg_n_d  = '1;
    dp_n_d   = 1'b1;
    cur_char = msg_mem[idx_q];
    if (state_q == SHOW && drive_on) begin
      seg_n_d = ~seg_lit(cur_char[6:0]);
      dp_n_d  = ~cur_char[7];
    end
  end

  // NOTE: all state updates use <= so every register samples the pre-edge values.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_n_q <= '1;
      dp_n_q  <= 1'b1;
    end else begin
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      if (abort) begin
        state_q <= IDLE;
        fill_q  <= '0;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE, LOAD: if (wr_fire) begin
            fill_q <= fill_q + FILL_W'(1);
            if (wr.wr_last || fill_q == FULL_MINUS1) begin
              state_q <= SHOW;
              idx_q   <= '0;
              cnt_q   <= '0;
            end else begin
              state_q <= LOAD;
            end
          end
          SHOW: if (cnt_q == DWELL_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          GAP: if (cnt_q == BLANK_LAST) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            // Wrap after the last stored character so the message repeats.
            idx_q   <= ({1'b0, idx_q} == fill_q - FILL_W'(1)) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seg16_message_scroller.sv
// Scoreboard bench for seg16_message_scroller (DWELL=8, BLANK=4): stimulus queues
// cycle-tagged expectations, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_seg16_message_scroller;
  typedef enum {K_SEG, K_DP, K_BUSY, K_IDX, K_RDY} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic [2:0]  char_index;
  logic [15:0] seg_n;
  logic        dp_n;
  logic [15:0] mon_act;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  seg16_message_scroller_if wr_if();
`ifdef SEG16_PWM_DIM_EN
  logic [3:0] brightness = 4'd4;
`endif

  seg16_message_scroller #(.MSG_DEPTH(8), .DWELL_CYCLES(8), .BLANK_CYCLES(4)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .wr         (wr_if),
    .abort      (abort),
`ifdef SEG16_PWM_DIM_EN
    .brightness (brightness),
`endif
    .busy       (busy),
    .char_index (char_index),
    .seg_n      (seg_n),
    .dp_n       (dp_n)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_at(input int c, input kind_e k, input logic [15:0] v, input string name);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic expect_run(input int c, input int n, input logic [15:0] seg, input logic dp,
                            input string name);
    for (int i = 0; i < n; i++) begin
      expect_at(c + i, K_SEG, seg, name);
      expect_at(c + i, K_DP, {15'b0, dp}, name);
    end
  endtask

  task automatic expect_idle(input int c, input string name);
    expect_at(c, K_BUSY, 16'd0, name);
    expect_at(c, K_RDY, 16'd1, name);
    expect_at(c, K_IDX, 16'd0, name);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic put(input logic [7:0] d, input logic last);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    wr_if.wr_last  = last;
    @(negedge CLK);
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge CLK) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        case (sb_q[i].kind)
          K_SEG:   mon_act = seg_n;
          K_DP:    mon_act = {15'b0, dp_n};
          K_BUSY:  mon_act = {15'b0, busy};
          K_IDX:   mon_act = {13'b0, char_index};
          default: mon_act = {15'b0, wr_if.wr_ready};
        endcase
        check($sformatf("%s/%s", sb_q[i].name, sb_q[i].kind.name()), mon_act, sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    int k, p;
    logic [7:0] ch;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;
    wr_if.wr_last  = 1'b0;

    // Reset state while reset_n is held low.
    expect_idle(2, "reset");
    expect_at(2, K_SEG, 16'hFFFF, "reset");
    expect_at(2, K_DP, 16'd1, "reset");
    wait_until(3);
    reset_n = 1'b1;

`ifdef SEG16_PWM_DIM_EN
    // Released at cycle 3: pwm seen by the output register at cycle c is (c-4) mod 16.
    // Writing "0" now gives SHOW 4..11/16..23 -> lit output cycles 5..12 and 17..24.
    k = cyc;
    p = k + 1;
    for (int c = p + 1; c <= p + 20; c++) begin
      if (c == 5 || c == 6 || c == 7 || (c >= 20 && c <= 23))
        expect_at(c, K_SEG, 16'h00FF, "pwm4_on");
      else
        expect_at(c, K_SEG, 16'hFFFF, "pwm4_off");
    end
    put(8'h30, 1'b1);
    wait_until(24);
    brightness = 4'd0;
    expect_run(29, 8, 16'hFFFF, 1'b1, "pwm0_dark");
    wait_until(38);
`else
    // "0","1": 00FF x8, blank x4, CFFF x8, blank x4, then 00FF again; abort mid-SHOW.
    wait_until(5);
    k = cyc;
    p = k + 2;
    expect_at(k + 1, K_RDY, 16'd1, "s1_load");
    expect_at(k + 1, K_BUSY, 16'd0, "s1_load");
    expect_at(p, K_BUSY, 16'd1, "s1_show");
    expect_at(p, K_RDY, 16'd0, "s1_show");
    expect_at(p, K_SEG, 16'hFFFF, "s1_show_lag");
    expect_run(p + 1, 8, 16'h00FF, 1'b1, "s1_char0");
    expect_run(p + 9, 4, 16'hFFFF, 1'b1, "s1_gap0");
    expect_run(p + 13, 8, 16'hCFFF, 1'b1, "s1_char1");
    expect_run(p + 21, 4, 16'hFFFF, 1'b1, "s1_gap1");
    expect_run(p + 25, 2, 16'h00FF, 1'b1, "s1_wrap");
    expect_at(p + 11, K_IDX, 16'd0, "s1_idx");
    expect_at(p + 12, K_IDX, 16'd1, "s1_idx");
    expect_at(p + 24, K_IDX, 16'd0, "s1_idx_wrap");
    expect_idle(p + 28, "s1_abort");
    expect_at(p + 28, K_SEG, 16'h00FF, "s1_abort_lag");
    expect_run(p + 29, 1, 16'hFFFF, 1'b1, "s1_abort_blank");
    put(8'h30, 1'b0);
    put(8'h31, 1'b1);
    wait_until(p + 27);
    do_abort();
    wait_until(p + 30);

    // Eight characters "0".."7" with no wr_last; writes during display are ignored.
    k = cyc;
    p = k + 8;
    expect_at(k + 7, K_RDY, 16'd1, "s2_fill7");
    expect_at(k + 7, K_BUSY, 16'd0, "s2_fill7");
    expect_at(p, K_RDY, 16'd0, "s2_full");
    expect_at(p, K_BUSY, 16'd1, "s2_full");
    for (int i = 0; i < 8; i++) expect_at(p + 12 * i, K_IDX, 16'(i), "s2_idx");
    expect_at(p + 96, K_IDX, 16'd0, "s2_idx_wrap");
    expect_at(p + 30, K_RDY, 16'd0, "s2_ignore_wr");
    expect_run(p + 13, 1, 16'hCFFF, 1'b1, "s2_char1");
    expect_run(p + 25, 1, 16'h11E7, 1'b1, "s2_char2");
    expect_run(p + 97, 1, 16'h00FF, 1'b1, "s2_char0_kept");
    expect_run(p + 121, 1, 16'h11E7, 1'b1, "s2_char2_kept");
    expect_idle(p + 123, "s2_abort");
    expect_at(p + 123, K_SEG, 16'h11E7, "s2_abort_lag");
    expect_run(p + 124, 1, 16'hFFFF, 1'b1, "s2_abort_blank");
    for (int i = 0; i < 8; i++) begin
      ch = 8'h30 + 8'(i);
      put(ch, 1'b0);
    end
    wait_until(p + 20);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h7E;
    wr_if.wr_last  = 1'b1;
    wait_until(p + 40);
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    wait_until(p + 122);
    do_abort();
    wait_until(p + 125);

    // Abort together with a last-character write: abort wins, write discarded.
    k = cyc;
    expect_idle(k + 1, "s3_abort_wins");
    expect_at(k + 3, K_BUSY, 16'd0, "s3_still_idle");
    expect_at(k + 3, K_SEG, 16'hFFFF, "s3_still_idle");
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h30;
    wr_if.wr_last  = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    abort = 1'b0;
    wait_until(k + 4);

    // Sole character 8'hAD: '-' with decimal point, alternating SHOW/GAP on index 0.
    k = cyc;
    p = k + 1;
    expect_run(p + 1, 8, 16'hFFE7, 1'b0, "s4_dash");
    expect_run(p + 9, 4, 16'hFFFF, 1'b1, "s4_gap");
    expect_at(p + 12, K_IDX, 16'd0, "s4_idx");
    expect_run(p + 13, 2, 16'hFFE7, 1'b0, "s4_again");
    put(8'hAD, 1'b1);
    wait_until(p + 15);
    do_abort();
    wait_until(p + 18);

    // "~" lights everything; "a" and "A" share one glyph.
    k = cyc;
    p = k + 3;
    expect_run(p + 1, 2, 16'h0000, 1'b1, "s5_tilde");
    expect_run(p + 13, 2, 16'h0CE7, 1'b1, "s5_lower_a");
    expect_run(p + 25, 2, 16'h0CE7, 1'b1, "s5_upper_A");
    put(8'h7E, 1'b0);
    put(8'h61, 1'b0);
    put(8'h41, 1'b1);
    wait_until(p + 27);
    do_abort();
    wait_until(p + 30);

    // Reset asserted between edges mid-SHOW must blank the display at once.
    k = cyc;
    p = k + 1;
    expect_run(p + 1, 3, 16'h00FF, 1'b1, "s6_lit");
    put(8'h30, 1'b1);
    wait_until(p + 4);
    @(posedge CLK);
    #2;
    reset_n = 1'b0;
    k = cyc;
    expect_idle(k, "s6_async_reset");
    expect_at(k, K_SEG, 16'hFFFF, "s6_async_reset");
    expect_at(k, K_DP, 16'd1, "s6_async_reset");
    @(negedge CLK);
    #1;
    reset_n = 1'b1;
`endif

    repeat (2) @(negedge CLK);
    #1;
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
